// File: rtl/rbz_vblank_commit_sched_pkg.sv
// -----------------------------------------------------------------------------
// rbz_commit_pkg
// Shared definitions for the vblank commit scheduler: default bus widths,
// the scheduler state encoding and a constant-foldable ceil(log2) helper
// used to size pointers and the FIFO level counter.
// -----------------------------------------------------------------------------
package rbz_commit_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_DEPTH  = 4;

    // WAIT_VB: holding queued writes until the next vblank rising edge.
    // DRAIN  : inside a vblank window, committing one entry per cycle.
    typedef enum logic {
        WAIT_VB = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    // ceil(log2(value)); value >= 1. Used at elaboration time only.
    function automatic int clog2(input int value);
        int result    = 0;
        int remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rbz_vblank_commit_sched_if.sv
// -----------------------------------------------------------------------------
// rbz_vblank_commit_sched_if
// Bundles the two requester handshakes (A: view-vector decoder, B: general
// register decoder) and the register-bank write port / status outputs of the
// commit scheduler.
//   slave  : the scheduler (accepts commands, drives the bank write port)
//   master : the surroundings (requesters and register bank)
// Signals:
//   a_valid/a_ready/a_addr/a_data   requester A command handshake
//   b_valid/b_ready/b_addr/b_data   requester B command handshake
//   o_wr_en/o_wr_addr/o_wr_data     registered register-bank write port
//   o_level                         FIFO occupancy
//   o_frame_commit                  one-cycle pulse after a productive window
// -----------------------------------------------------------------------------
interface rbz_vblank_commit_sched_if
    import rbz_commit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LVL_W  = clog2(DEF_DEPTH) + 1
);

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;

    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic [LVL_W-1:0]  o_level;
    logic              o_frame_commit;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output o_wr_en, o_wr_addr, o_wr_data, o_level, o_frame_commit
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  o_wr_en, o_wr_addr, o_wr_data, o_level, o_frame_commit
    );

endinterface

// File: rtl/rbz_vblank_commit_sched_fifo.sv
// -----------------------------------------------------------------------------
// rbz_cmd_fifo
// Synchronous FIFO holding {addr,data} commands. Push is ignored when full,
// pop is ignored when empty; simultaneous push and pop keep the level.
// Read data is the current head (show-ahead), valid whenever !o_empty.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_wdata   write request and data
//   i_pop             remove the head entry
//   o_rdata           head entry
//   o_level           number of stored entries (0..DEPTH)
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module rbz_cmd_fifo
    import rbz_commit_pkg::*;
#(
    parameter int  WIDTH = DEF_ADDR_W + DEF_DATA_W,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int PTR_W = clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // NOTE: storage has no reset; an entry is only ever read after it has
    // been written, and the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/rbz_vblank_commit_sched.sv
// -----------------------------------------------------------------------------
// rbz_vblank_commit_sched
// Sole writer of the renderer's live register bank. Register-write commands
// from requester A (view vectors) and requester B (general registers) are
// round-robin arbitrated into a FIFO and only committed while vertical
// blanking is active, so view/config changes never tear a visible frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_vblank     vertical blank, synchronous to clk
//   bus (slave)  requester handshakes, registered bank write port,
//                FIFO level and the frame-commit pulse
// Timing: with the first vblank-high cycle t (after a low cycle), the first
// bank write strobe is high in cycle t+2, then one write per cycle while the
// FIFO is non-empty and vblank stays high.
// -----------------------------------------------------------------------------
module rbz_vblank_commit_sched
    import rbz_commit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_vblank,
    rbz_vblank_commit_sched_if.slave   bus
);

    localparam int LVL_W = clog2(DEPTH) + 1;
    localparam int CMD_W = ADDR_W + DATA_W;

    // Arbiter / FIFO
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_push;
    logic [CMD_W-1:0]  w_push_cmd;
    logic [CMD_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              r_prefer_a;

    // Commit FSM
    state_e            r_state;
    state_e            w_next_state;
    logic              w_vb_rise;
    logic              w_pop;
    logic              w_commit_pulse;
    logic              r_vb_prev;
    logic              r_committed;

    // Registered bank write port
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_frame_commit;

    // -------------------------------------------------------------------------
    // Round-robin arbiter. Full is the pre-pop occupancy, so a pop in a full
    // cycle does not open a slot until the following cycle.
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!w_full) begin
            if (bus.a_valid && (!bus.b_valid || r_prefer_a)) begin
                w_grant_a = 1'b1;
            end else if (bus.b_valid) begin
                w_grant_b = 1'b1;
            end
        end
    end

    assign w_push     = w_grant_a || w_grant_b;
    assign w_push_cmd = w_grant_a ? {bus.a_addr, bus.a_data}
                                  : {bus.b_addr, bus.b_data};

    // Pointer moves only on a grant; after reset A wins a tie.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefer_a <= 1'b1;
        end else if (w_grant_a) begin
            r_prefer_a <= 1'b0;
        end else if (w_grant_b) begin
            r_prefer_a <= 1'b1;
        end
    end

    rbz_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_addr, w_head_data} = w_head;

    // -------------------------------------------------------------------------
    // Commit FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_VB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Commit FSM: next state. Only a fresh vblank rising edge opens a window.
    assign w_vb_rise = i_vblank && !r_vb_prev;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_VB: if (w_vb_rise) w_next_state = DRAIN;
            DRAIN:   if (!i_vblank) w_next_state = WAIT_VB;
            default: w_next_state = WAIT_VB;
        endcase
    end

    // Commit FSM: outputs. The window closes on the first vblank-low cycle in
    // DRAIN; that same cycle decides the frame-commit pulse.
    always_comb begin
        w_pop          = 1'b0;
        w_commit_pulse = 1'b0;
        if (r_state == DRAIN) begin
            w_pop          = i_vblank && !w_empty;
            w_commit_pulse = !i_vblank && r_committed;
        end
    end

    // vblank history resets high so a vblank already active at reset release
    // is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vb_prev   <= 1'b1;
            r_committed <= 1'b0;
        end else begin
            r_vb_prev <= i_vblank;
            if (r_state == WAIT_VB && w_vb_rise) begin
                r_committed <= 1'b0;
            end else if (w_pop) begin
                r_committed <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered bank write port. Address/data hold their last value between
    // strobes; the bank only looks at them while o_wr_en is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_frame_commit <= 1'b0;
        end else begin
            r_wr_en        <= w_pop;
            r_frame_commit <= w_commit_pulse;
            if (w_pop) begin
                r_wr_addr <= w_head_addr;
                r_wr_data <= w_head_data;
            end
        end
    end

    assign bus.a_ready        = w_grant_a;
    assign bus.b_ready        = w_grant_b;
    assign bus.o_wr_en        = r_wr_en;
    assign bus.o_wr_addr      = r_wr_addr;
    assign bus.o_wr_data      = r_wr_data;
    assign bus.o_level        = w_level;
    assign bus.o_frame_commit = r_frame_commit;

endmodule

// File: tb/tb_rbz_vblank_commit_sched.sv
// -----------------------------------------------------------------------------
// tb_rbz_vblank_commit_sched
// Directed bench for the vblank commit scheduler. A queue-based reference
// model is advanced once per cycle on the falling edge and compared against
// every DUT output; directed sequences add hand-computed literal checks.
// Inputs change 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rbz_vblank_commit_sched;
    import rbz_commit_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic vblank;

    rbz_vblank_commit_sched_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LVL_W  (LVL_W)
    ) bus ();

    rbz_vblank_commit_sched #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vblank (vblank),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests        = 0;
    int fails        = 0;
    int wr_count     = 0;
    int commit_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: queue of pending commands plus window bookkeeping.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum {LAST_A, LAST_B} last_e;

    cmd_t              m_q[$];
    last_e             m_last;
    bit                m_in_window;
    bit                m_vb_seen;
    bit                m_window_wrote;
    bit                m_wr_en;
    bit                m_commit;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    function automatic void model_reset();
        m_q.delete();
        m_last         = LAST_B;
        m_in_window    = 1'b0;
        m_vb_seen      = 1'b1;
        m_window_wrote = 1'b0;
        m_wr_en        = 1'b0;
        m_commit       = 1'b0;
        m_addr         = '0;
        m_data         = '0;
    endfunction

    always @(negedge clk) begin
        bit   full;
        bit   ga;
        bit   gb;
        bit   pop;
        cmd_t c;
        if (!rst_n) begin
            model_reset();
            check("rst_wr_en",  bus.o_wr_en,        1'b0);
            check("rst_addr",   bus.o_wr_addr,      '0);
            check("rst_data",   bus.o_wr_data,      '0);
            check("rst_level",  bus.o_level,        '0);
            check("rst_commit", bus.o_frame_commit, 1'b0);
        end else begin
            full = (m_q.size() == DEPTH);
            ga   = !full && bus.a_valid && (!bus.b_valid || m_last == LAST_B);
            gb   = !full && bus.b_valid && !ga;
            check("a_ready",   bus.a_ready,        ga);
            check("b_ready",   bus.b_ready,        gb);
            check("level",     bus.o_level,        m_q.size());
            check("wr_en",     bus.o_wr_en,        m_wr_en);
            check("wr_addr",   bus.o_wr_addr,      m_addr);
            check("wr_data",   bus.o_wr_data,      m_data);
            check("commit",    bus.o_frame_commit, m_commit);
            if (bus.o_wr_en)        wr_count++;
            if (bus.o_frame_commit) commit_count++;

            // What the outputs must be after the coming rising edge.
            pop      = m_in_window && vblank && (m_q.size() > 0);
            m_commit = m_in_window && !vblank && m_window_wrote;
            m_wr_en  = pop;
            if (pop) begin
                c              = m_q.pop_front();
                m_addr         = c.addr;
                m_data         = c.data;
                m_window_wrote = 1'b1;
            end
            if (ga) begin
                m_q.push_back({bus.a_addr, bus.a_data});
                m_last = LAST_A;
            end
            if (gb) begin
                m_q.push_back({bus.b_addr, bus.b_data});
                m_last = LAST_B;
            end
            if (!m_in_window && vblank && !m_vb_seen) begin
                m_in_window    = 1'b1;
                m_window_wrote = 1'b0;
            end else if (m_in_window && !vblank) begin
                m_in_window = 1'b0;
            end
            m_vb_seen = vblank;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        vblank      = 1'b0;
        rst_n       = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic push_a_run(input int n, input logic [ADDR_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.a_valid = 1'b1;
            bus.a_addr  = base + ADDR_W'(i);
            bus.a_data  = 24'h400000 + DATA_W'(i);
            step(1);
        end
        bus.a_valid = 1'b0;
    endtask

    int wr0;
    int cm0;

    initial begin
        rst_n       = 1'b0;
        vblank      = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
        step(2);
        rst_n = 1'b1;

        // 1) vblank high across reset release is ignored; single A write.
        bus.a_valid = 1'b1;
        bus.a_addr  = 4'd3;
        bus.a_data  = 24'h123456;
        step(1);
        bus.a_valid = 1'b0;
        check("t1_level_after_push", bus.o_level, 3'd1);
        step(3);
        check("t1_no_write_stale_vb", wr_count, 0);
        vblank = 1'b0;
        step(2);
        vblank = 1'b1;
        step(1);
        check("t1_wr_en_t1", bus.o_wr_en, 1'b0);
        step(1);
        check("t1_wr_en_t2",  bus.o_wr_en,   1'b1);
        check("t1_wr_addr",   bus.o_wr_addr, 4'd3);
        check("t1_wr_data",   bus.o_wr_data, 24'h123456);
        step(1);
        check("t1_wr_en_done", bus.o_wr_en, 1'b0);
        vblank = 1'b0;
        step(1);
        check("t1_commit_pulse", bus.o_frame_commit, 1'b1);
        step(1);
        check("t1_commit_clear", bus.o_frame_commit, 1'b0);

        // 2/3) Both requesters every cycle: A,B,A,B then full; B waits out
        // the full cycle in which the first pop happens.
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            bus.a_valid = 1'b1;
            bus.b_valid = 1'b1;
            bus.a_addr  = ADDR_W'(i);
            bus.a_data  = 24'hA00000 + DATA_W'(i);
            bus.b_addr  = ADDR_W'(8 + i);
            bus.b_data  = 24'hB00000 + DATA_W'(i);
            step(1);
        end
        check("t2_level_full", bus.o_level,  3'd4);
        check("t2_a_ready_0",  bus.a_ready,  1'b0);
        check("t2_b_ready_0",  bus.b_ready,  1'b0);
        bus.a_valid = 1'b0;
        bus.b_addr  = 4'hE;
        bus.b_data  = 24'hB0000E;
        vblank      = 1'b1;
        step(1);
        check("t3_b_blocked_on_pop", bus.b_ready, 1'b0);
        check("t3_level_4",          bus.o_level, 3'd4);
        step(1);
        check("t3_level_3a",  bus.o_level,   3'd3);
        check("t2_w0_addr",   bus.o_wr_addr, 4'd0);
        check("t2_w0_data",   bus.o_wr_data, 24'hA00000);
        check("t3_b_ready_1", bus.b_ready,   1'b1);
        step(1);
        bus.b_valid = 1'b0;
        check("t3_level_3b", bus.o_level,   3'd3);
        check("t2_w1_addr",  bus.o_wr_addr, 4'd9);
        check("t2_w1_data",  bus.o_wr_data, 24'hB00001);
        step(1);
        check("t2_w2_addr", bus.o_wr_addr, 4'd2);
        step(1);
        check("t2_w3_addr", bus.o_wr_addr, 4'd11);
        check("t2_w3_data", bus.o_wr_data, 24'hB00003);
        step(1);
        check("t3_w4_addr", bus.o_wr_addr, 4'hE);
        check("t3_w4_en",   bus.o_wr_en,   1'b1);
        step(1);
        check("t2_drained", bus.o_wr_en, 1'b0);
        vblank = 1'b0;
        step(1);
        check("t2_commit", bus.o_frame_commit, 1'b1);

        // 4) Three vblank-high cycles (one arms, two drain) with 4 queued.
        reset_dut();
        push_a_run(4, 4'd1);
        check("t4_level_4", bus.o_level, 3'd4);
        wr0 = wr_count;
        cm0 = commit_count;
        vblank = 1'b1;
        step(3);
        vblank = 1'b0;
        step(3);
        check("t4_two_writes", wr_count - wr0,     2);
        check("t4_level_2",    bus.o_level,        3'd2);
        check("t4_one_commit", commit_count - cm0, 1);
        vblank = 1'b1;
        step(6);
        vblank = 1'b0;
        step(2);
        check("t4_all_writes", wr_count - wr0,     4);
        check("t4_level_0",    bus.o_level,        3'd0);
        check("t4_two_commit", commit_count - cm0, 2);

        // 5) Empty window, then a push landing mid-window.
        wr0 = wr_count;
        cm0 = commit_count;
        vblank = 1'b1;
        step(4);
        vblank = 1'b0;
        step(2);
        check("t5_empty_no_write",  wr_count - wr0,     0);
        check("t5_empty_no_commit", commit_count - cm0, 0);
        vblank = 1'b1;
        step(3);
        bus.b_valid = 1'b1;
        bus.b_addr  = 4'd9;
        bus.b_data  = 24'h999999;
        step(1);
        bus.b_valid = 1'b0;
        check("t5_wr_en_p1", bus.o_wr_en, 1'b0);
        step(1);
        check("t5_wr_en_p2", bus.o_wr_en,   1'b1);
        check("t5_wr_addr",  bus.o_wr_addr, 4'd9);
        check("t5_wr_data",  bus.o_wr_data, 24'h999999);
        vblank = 1'b0;
        step(1);
        check("t5_commit", bus.o_frame_commit, 1'b1);

        // 6) Reset in the middle of a drain with 3 entries still queued.
        reset_dut();
        push_a_run(4, 4'd5);
        vblank = 1'b1;
        step(2);
        check("t6_pre_wr_en", bus.o_wr_en, 1'b1);
        check("t6_pre_level", bus.o_level, 3'd3);
        rst_n = 1'b0;
        #1;
        check("t6_async_wr_en", bus.o_wr_en, 1'b0);
        check("t6_async_level", bus.o_level, 3'd0);
        step(1);
        rst_n = 1'b1;
        wr0 = wr_count;
        cm0 = commit_count;
        step(4);
        vblank = 1'b0;
        step(2);
        vblank = 1'b1;
        step(4);
        vblank = 1'b0;
        step(2);
        check("t6_no_writes",  wr_count - wr0,     0);
        check("t6_no_commits", commit_count - cm0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
